iboard_start_sequencer: RTL and testbench

Power-up and start sequencer for the interface-board CPLD. It owns the shared JTAG/start lines toward the chip. After reset it holds the chip reset low for a fixed count, then drives a TAP reset sequence (TMS high for N TCK clocks). It then hands TCK/TMS/TDI to the host as a passthrough. On each host start request it takes back the shared TMS_SYSSTART line to issue one fixed-length start pulse.

---
 rtl/iboard_start_sequencer.sv | 159 +++++++++++++++
 tb/tb_iboard_start_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iboard_start_sequencer.sv
// Interface-board power-up/start sequencer: chip reset hold, TAP reset, host passthrough and
// host-requested start pulses on the shared TMS_SYSSTART line.
module iboard_start_sequencer #(
  parameter int unsigned RST_CYCLES = 256,
  parameter int unsigned TLR_CLOCKS = 5,
  parameter int unsigned TCK_DIV    = 4,
  parameter int unsigned START_LEN  = 4,
  parameter int unsigned CNT_W      = 9
) (
  input  logic       CLK,
  input  logic       ARESET_L33,
  input  logic       SYSSTART33,
  input  logic       TMS33,
  input  logic       TCK33,
  input  logic       TDI33,
  output logic       ARESET_L,
  output logic       TMS_SYSSTART,
  output logic       TCK,
  output logic       TDI,
  output logic       BUSY,
  output logic [2:0] STATE
);

  localparam int unsigned DivW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] RstLast   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TlrLast   = CNT_W'(TLR_CLOCKS - 1);
  localparam logic [CNT_W-1:0] StartLast = CNT_W'(START_LEN - 1);
  localparam logic [DivW-1:0]  DivLast   = DivW'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    StResetHold = 3'd0,
    StTapReset  = 3'd1,
    StIdle      = 3'd2,
    StStart     = 3'd3,
    StStartWait = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             areset_l_q, areset_l_d;
  logic             pending_q, pending_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge CLK or negedge ARESET_L33) begin
    if (!ARESET_L33) begin
      state_q    <= StResetHold;
      cnt_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
      areset_l_q <= 1'b0;
      pending_q  <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      areset_l_q <= areset_l_d;
      pending_q  <= pending_d;
      s1_q       <= SYSSTART33;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    tck_d      = 1'b0;
    tms_d      = 1'b0;
    tdi_d      = 1'b0;
    areset_l_d = 1'b1;
    // Only one request is queued; extra rises simply re-set the same flag.
    pending_d  = pending_q | rise;
    unique case (state_q)
      StResetHold: begin
        areset_l_d = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == RstLast) begin
          state_d    = StTapReset;
          cnt_d      = '0;
          div_d      = '0;
          areset_l_d = 1'b1;
          tms_d      = 1'b1;
        end
      end
      StTapReset: begin
        tms_d = 1'b1;
        tck_d = tck_q;
        if (div_q == DivLast) begin
          div_d = '0;
          tck_d = ~tck_q;
          // cnt_q counts TCK falling edges here.
          if (tck_q) begin
            if (cnt_q == TlrLast) begin
              state_d = StIdle;
              cnt_d   = '0;
              tck_d   = 1'b0;
              tms_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StIdle: begin
        if (rise || pending_q) begin
          state_d   = StStart;
          pending_d = 1'b0;
          cnt_d     = '0;
          tms_d     = 1'b1;
        end
      end
      StStart: begin
        tms_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == StartLast) begin
          state_d = StStartWait;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end
      end
      StStartWait: begin
        if (!s2_q) state_d = StIdle;
      end
      default: begin
        state_d    = StResetHold;
        cnt_d      = '0;
        div_d      = '0;
        areset_l_d = 1'b0;
      end
    endcase
  end

  // Mux select is the registered state, so passthrough only switches at a state edge.
  assign TCK          = (state_q == StIdle) ? TCK33 : tck_q;
  assign TDI          = (state_q == StIdle) ? TDI33 : tdi_q;
  assign TMS_SYSSTART = (state_q == StIdle) ? TMS33 : tms_q;
  assign ARESET_L     = areset_l_q;
  assign BUSY         = (state_q != StIdle);
  assign STATE        = state_q;

endmodule

// File: tb/tb_iboard_start_sequencer.sv
// Scoreboard bench for iboard_start_sequencer with default parameters.
module tb_iboard_start_sequencer;

  logic       CLK = 1'b0;
  logic       ARESET_L33, SYSSTART33, TMS33, TCK33, TDI33;
  logic       ARESET_L, TMS_SYSSTART, TCK, TDI, BUSY;
  logic [2:0] STATE;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_v;
  logic [7:0] obs_v;

  iboard_start_sequencer dut (
    .CLK         (CLK),
    .ARESET_L33  (ARESET_L33),
    .SYSSTART33  (SYSSTART33),
    .TMS33       (TMS33),
    .TCK33       (TCK33),
    .TDI33       (TDI33),
    .ARESET_L    (ARESET_L),
    .TMS_SYSSTART(TMS_SYSSTART),
    .TCK         (TCK),
    .TDI         (TDI),
    .BUSY        (BUSY),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  assign obs_v = {ARESET_L, TMS_SYSSTART, TCK, TDI, BUSY, STATE};

  function automatic logic [7:0] pack(input logic arl, input logic tms, input logic tck,
                                      input logic tdi, input logic busy, input logic [2:0] st);
    return {arl, tms, tck, tdi, busy, st};
  endfunction

  function automatic logic [7:0] idle_exp();
    return pack(1'b1, TMS33, TCK33, TDI33, 1'b0, 3'd2);
  endfunction

  // Expected outputs just after edge k following reset release.
  function automatic logic [7:0] seq_exp(input int k);
    logic t;
    if (k < 256) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    if (k < 296) begin
      t = (((k - 256) / 4) % 2) == 1;
      return pack(1'b1, 1'b1, t, 1'b0, 1'b1, 3'd1);
    end
    return idle_exp();
  endfunction

  task automatic test_reset();
    ARESET_L33 = 1'b0;
    SYSSTART33 = 1'b0;
    TMS33 = 1'b1;
    TCK33 = 1'b0;
    TDI33 = 1'b1;
    repeat (2) @(negedge CLK);
    sb_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b", obs_v, exp_v);
    end
    ARESET_L33 = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      sb_q.push_back(seq_exp(k));
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_tap_reset(input bit pulse);
    for (int k = 257; k <= 296; k++) begin
      SYSSTART33 = pulse && ((k >= 260 && k < 263) || (k >= 268 && k < 271));
      sb_q.push_back(seq_exp(k));
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL tap_reset edge=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 16; i++) begin
      TMS33 = 1'($urandom_range(0, 1));
      TCK33 = 1'($urandom_range(0, 1));
      TDI33 = 1'($urandom_range(0, 1));
      sb_q.push_back(idle_exp());
      #2;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL passthrough i=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_start_held();
    SYSSTART33 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) SYSSTART33 = 1'b0;
      TMS33 = 1'($urandom_range(0, 1));
      TCK33 = 1'($urandom_range(0, 1));
      TDI33 = 1'($urandom_range(0, 1));
      if (k <= 2 || k >= 23) sb_q.push_back(idle_exp());
      else if (k <= 6) sb_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3));
      else sb_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL start_held edge=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_start();
    TMS33 = 1'b0;
    TCK33 = 1'b1;
    TDI33 = 1'b1;
    SYSSTART33 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k <= 2) sb_q.push_back(idle_exp());
      else sb_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3));
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL mid_start edge=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
    #2;
    ARESET_L33 = 1'b0;
    sb_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", obs_v, exp_v);
    end
    SYSSTART33 = 1'b0;
  endtask

  task automatic test_pending();
    TMS33 = 1'b0;
    TCK33 = 1'b1;
    TDI33 = 1'b1;
    for (int k = 297; k <= 312; k++) begin
      if (k <= 300) sb_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3));
      else if (k == 301) sb_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
      else sb_q.push_back(idle_exp());
      @(posedge CLK);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL pending edge=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap_reset(1'b0);
    test_passthrough();
    test_start_held();
    test_reset_mid_start();
    test_reset();
    test_tap_reset(1'b1);
    test_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
